// File: rtl/crc_frame_rx_if.sv
// Bus bundle for the serial CRC frame receiver.
// The master side presents the serial stream and polynomial and observes the
// frame results. The slave side is the receiver itself.
interface crc_frame_rx_if #(
    parameter int DATA_W = 8
) ();

    logic [3:0]        ctrl_poly_en;
    logic              sof;
    logic              bit_vld;
    logic              bit_in;
    logic [DATA_W-1:0] data_out;
    logic              frame_vld;
    logic              crc_err;
    logic [3:0]        crc_rem;
    logic              busy;

    modport master (
        output ctrl_poly_en,
        output sof,
        output bit_vld,
        output bit_in,
        input  data_out,
        input  frame_vld,
        input  crc_err,
        input  crc_rem,
        input  busy
    );

    modport slave (
        input  ctrl_poly_en,
        input  sof,
        input  bit_vld,
        input  bit_in,
        output data_out,
        output frame_vld,
        output crc_err,
        output crc_rem,
        output busy
    );

endinterface

// File: rtl/crc_frame_rx.sv
// Serial frame receiver: a DATA_W-bit payload followed by a 4-bit CRC field,
// both MSB first. The CRC is checked with a programmable generator polynomial
// (x^4 implicit). The results of the most recent complete frame are held on
// the outputs until another frame completes.
module crc_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    crc_frame_rx_if.slave bus
);

    // The counter tracks payload bits in DATA and CRC bits in CRC, so it must
    // reach max(DATA_W-1, 3).
    localparam int CNT_MAX = (DATA_W > 4) ? DATA_W : 4;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_CRC  = 2'b10
    } state_t;

    // One step of the CRC shift register. Bit i of poly adds the x^i
    // feedback tap, and the incoming bit enters at the x^0 end.
    function automatic logic [3:0] crc_step(
        input logic [3:0] rem,
        input logic [3:0] poly,
        input logic       b
    );
        logic       fb;
        logic [3:0] nxt;
        fb     = rem[3];
        nxt[0] = poly[0] ? (b ^ fb)      : b;
        nxt[1] = poly[1] ? (rem[0] ^ fb) : rem[0];
        nxt[2] = poly[2] ? (rem[1] ^ fb) : rem[1];
        nxt[3] = poly[3] ? (rem[2] ^ fb) : rem[2];
        return nxt;
    endfunction

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_rem;
    logic [DATA_W-1:0] r_payload;
    logic [DATA_W-1:0] r_data_out;
    logic              r_frame_vld;
    logic              r_crc_err;
    logic [3:0]        r_crc_rem;
    logic              r_busy;

    logic [3:0]        w_rem_base;
    logic [3:0]        w_rem_next;
    logic [IDX_W-1:0]  w_bit_idx;
    logic              w_last_pay;
    logic              w_last_crc;

    // A start-of-frame bit restarts the remainder from zero. Any other bit
    // continues from the current remainder.
    always_comb begin
        w_rem_base = r_rem;
        if (bus.sof) begin
            w_rem_base = 4'b0000;
        end else begin
            w_rem_base = r_rem;
        end
        w_rem_next = crc_step(w_rem_base, bus.ctrl_poly_en, bus.bit_in);
    end

    // Payload bit position and end-of-field detection, both from the bit counter.
    always_comb begin
        w_bit_idx  = IDX_W'(DATA_W - 1) - IDX_W'(r_cnt);
        w_last_pay = (r_cnt == CNT_W'(DATA_W - 1));
        w_last_crc = (r_cnt == CNT_W'(3));
    end

    // Frame FSM: accepts gated bits, builds the payload and remainder, and
    // registers the result on the 4th CRC bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= 4'b0000;
            r_payload   <= '0;
            r_data_out  <= '0;
            r_frame_vld <= 1'b0;
            r_crc_err   <= 1'b0;
            r_crc_rem   <= 4'b0000;
            r_busy      <= 1'b0;
        end else begin
            r_frame_vld <= 1'b0;
            if (bus.bit_vld) begin
                if (bus.sof) begin
                    // A new frame starts here, from any state. A partial frame is
                    // dropped without touching the held outputs.
                    r_rem                <= w_rem_next;
                    r_payload[DATA_W-1]  <= bus.bit_in;
                    r_busy               <= 1'b1;
                    if (DATA_W == 1) begin
                        r_state <= ST_CRC;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_DATA;
                        r_cnt   <= CNT_W'(1);
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            // Stray bits between frames are ignored.
                            r_state <= ST_IDLE;
                        end
                        ST_DATA: begin
                            r_rem                <= w_rem_next;
                            r_payload[w_bit_idx] <= bus.bit_in;
                            if (w_last_pay) begin
                                r_state <= ST_CRC;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        ST_CRC: begin
                            r_rem <= w_rem_next;
                            if (w_last_crc) begin
                                r_state     <= ST_IDLE;
                                r_cnt       <= '0;
                                r_busy      <= 1'b0;
                                r_data_out  <= r_payload;
                                r_crc_rem   <= w_rem_next;
                                r_crc_err   <= (w_rem_next != 4'b0000);
                                r_frame_vld <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            // Unreachable encoding: fall back to a clean idle.
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end else begin
                // No valid bit this cycle, so all frame state holds.
                r_state <= r_state;
            end
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.frame_vld = r_frame_vld;
    assign bus.crc_err   = r_crc_err;
    assign bus.crc_rem   = r_crc_rem;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_crc_frame_rx.sv
// Directed bench for crc_frame_rx with DATA_W=8 and polynomial x^4+x+1.
// Expected results are hand-computed:
//   A5 with CRC B -> remainder 0
//   A5 with CRC A -> remainder 1
module tb_crc_frame_rx;

    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    crc_frame_rx_if #(.DATA_W(DATA_W)) bus ();

    crc_frame_rx #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks     = 0;
    int n_fail       = 0;
    int cyc          = 0;
    int vld_cnt      = 0;
    int last_vld_cyc = 0;
    int prev_vld_cyc = 0;
    int start_cyc    = 0;
    int v0;

    always @(posedge clk) cyc <= cyc + 1;

    // Count frame_vld pulses and record the cycles in which they occur.
    always @(negedge clk) begin
        if (bus.frame_vld === 1'b1) begin
            vld_cnt      <= vld_cnt + 1;
            prev_vld_cyc <= last_vld_cyc;
            last_vld_cyc <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic b);
        @(negedge clk);
        bus.sof     = s;
        bus.bit_vld = v;
        bus.bit_in  = b;
        @(posedge clk);
        #1;
    endtask

    // Send a 12-bit frame MSB first with sof on the first bit.
    // gap_a and gap_b are 1-based bit numbers; 3 idle cycles follow each one.
    // During an idle cycle, sof and bit_in are held high while bit_vld is low.
    task automatic send_frame(input logic [11:0] bits, input int gap_a, input int gap_b);
        for (int i = 0; i < 12; i++) begin
            drive(logic'(i == 0), 1'b1, bits[11-i]);
            if (i == 0) start_cyc = cyc;
            if ((i + 1) == gap_a || (i + 1) == gap_b) begin
                repeat (3) drive(1'b1, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        bus.ctrl_poly_en = 4'b0011;
        bus.sof          = 1'b0;
        bus.bit_vld      = 1'b0;
        bus.bit_in       = 1'b0;
        rst_n            = 1'b0;
        #2;
        check_eq("rst_data",  32'(bus.data_out), 32'h0);
        check_eq("rst_vld",   32'(bus.frame_vld), 32'h0);
        check_eq("rst_err",   32'(bus.crc_err), 32'h0);
        check_eq("rst_rem",   32'(bus.crc_rem), 32'h0);
        check_eq("rst_busy",  32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bits accepted without sof while idle are ignored.
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        check_eq("idle_busy", 32'(bus.busy), 32'h0);
        check_eq("idle_vld",  32'(vld_cnt), 32'h0);

        // Good frame.
        v0 = vld_cnt;
        send_frame(12'hA5B, 0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("good_cnt",  32'(vld_cnt - v0), 32'd1);
        check_eq("good_data", 32'(bus.data_out), 32'hA5);
        check_eq("good_err",  32'(bus.crc_err), 32'h0);
        check_eq("good_rem",  32'(bus.crc_rem), 32'h0);
        check_eq("good_lat",  32'(last_vld_cyc - start_cyc), 32'd11);
        check_eq("good_vldlow", 32'(bus.frame_vld), 32'h0);
        check_eq("good_busy", 32'(bus.busy), 32'h0);

        // Bad CRC field.
        v0 = vld_cnt;
        send_frame(12'hA5A, 0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("bad_cnt",  32'(vld_cnt - v0), 32'd1);
        check_eq("bad_data", 32'(bus.data_out), 32'hA5);
        check_eq("bad_err",  32'(bus.crc_err), 32'h1);
        check_eq("bad_rem",  32'(bus.crc_rem), 32'h1);

        // Abort after 5 payload bits, then restart with a full good frame.
        v0 = vld_cnt;
        drive(1'b1, 1'b1, 1'b1);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        check_eq("abort_busy", 32'(bus.busy), 32'h1);
        check_eq("abort_hold_err", 32'(bus.crc_err), 32'h1);
        check_eq("abort_hold_rem", 32'(bus.crc_rem), 32'h1);
        check_eq("abort_hold_data", 32'(bus.data_out), 32'hA5);
        send_frame(12'hA5B, 0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("abort_cnt",  32'(vld_cnt - v0), 32'd1);
        check_eq("abort_data", 32'(bus.data_out), 32'hA5);
        check_eq("abort_err",  32'(bus.crc_err), 32'h0);

        // Good frame with 3-cycle gaps after bits 2 and 9.
        v0 = vld_cnt;
        send_frame(12'hA5B, 2, 9);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("gap_cnt",  32'(vld_cnt - v0), 32'd1);
        check_eq("gap_data", 32'(bus.data_out), 32'hA5);
        check_eq("gap_err",  32'(bus.crc_err), 32'h0);
        check_eq("gap_rem",  32'(bus.crc_rem), 32'h0);
        check_eq("gap_lat",  32'(last_vld_cyc - start_cyc), 32'd17);

        // Back-to-back frames; the second has payload 00 and CRC 0.
        v0 = vld_cnt;
        send_frame(12'hA5B, 0, 0);
        send_frame(12'h000, 0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("b2b_cnt",  32'(vld_cnt - v0), 32'd2);
        check_eq("b2b_gap",  32'(last_vld_cyc - prev_vld_cyc), 32'd12);
        check_eq("b2b_data", 32'(bus.data_out), 32'h00);
        check_eq("b2b_err",  32'(bus.crc_err), 32'h0);

        // Leave nonzero results, then reset asynchronously after the 6th bit.
        send_frame(12'hA5A, 0, 0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("pre_rst_err", 32'(bus.crc_err), 32'h1);
        v0 = vld_cnt;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data", 32'(bus.data_out), 32'h0);
        check_eq("arst_err",  32'(bus.crc_err), 32'h0);
        check_eq("arst_rem",  32'(bus.crc_rem), 32'h0);
        check_eq("arst_vld",  32'(bus.frame_vld), 32'h0);
        check_eq("arst_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("post_rst_cnt",  32'(vld_cnt - v0), 32'd0);
        check_eq("post_rst_busy", 32'(bus.busy), 32'h0);
        check_eq("post_rst_data", 32'(bus.data_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc_frame_rx.md
CRC_FRAME_RX -- requirements
Module: crc_frame_rx

Interface
REQ-001 Parameter: DATA_W, default 8, payload length in bits (legal range 1..64); CRC field width fixed at 4.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: ctrl_poly_en  input  4  generator polynomial taps.
  - Bit i enables the x^i term; x^4 is implicit.
  - Bit 0 is normally 1.
  - Sampled every accepted bit.
REQ-005 Port: sof  input  1  start of frame.
  - Qualified only by bit_vld.
  - Marks the first payload bit.
REQ-006 Port: bit_vld  input  1  bit_in valid this cycle.
REQ-007 Port: bit_in  input  1  serial data, payload MSB first, then CRC MSB first.
REQ-008 Port: data_out  output  DATA_W  last received payload.
REQ-009 Port: frame_vld  output  1  one-cycle pulse, frame complete.
REQ-010 Port: crc_err  output  1  CRC result of last frame, 1 = mismatch.
REQ-011 Port: crc_rem  output  4  remainder register of last completed frame.
REQ-012 Port: busy  output  1  high while FSM is in DATA or CRC.

Function
REQ-013 The FSM SHALL have states IDLE, DATA and CRC, and a bit counter sized for DATA_W.
REQ-014 A bit is accepted only when bit_vld=1; cycles with bit_vld=0 SHALL leave all state unchanged (gaps are allowed anywhere in a frame).
REQ-015 Remainder register update per accepted bit b, with fb = rem[3]:
  - rem[0] = ctrl_poly_en[0] ? b^fb : b
  - rem[i] = ctrl_poly_en[i] ? rem[i-1]^fb : rem[i-1], for i = 1..3
REQ-016 IDLE:
  - Accepted bit with sof=0 SHALL be ignored.
  - Accepted bit with sof=1 SHALL clear the remainder to 0 and then apply that bit.
  - The bit SHALL be stored as payload bit DATA_W-1.
  - Counter set to 1; go to DATA (or go to CRC if DATA_W=1).
REQ-017 DATA:
  - Each accepted bit SHALL update the remainder and shift into the payload shift register.
  - After DATA_W payload bits, go to CRC with the counter cleared.
REQ-018 CRC:
  - Each accepted bit SHALL update the remainder only.
  - The 4th accepted CRC bit SHALL return the FSM to IDLE.
REQ-019 On the clock edge that accepts the 4th CRC bit, the following SHALL register:
  - data_out = payload
  - crc_rem = updated remainder
  - crc_err = (updated remainder != 0)
  - frame_vld = 1 for exactly the following cycle
REQ-020 data_out, crc_err and crc_rem SHALL hold their values until the next frame completes.
REQ-021 Accepted bit with sof=1 while in DATA or CRC SHALL abort the current frame and restart it as in REQ-016.
  - An aborted frame SHALL produce no frame_vld pulse.
  - Outputs of the previous frame SHALL be unchanged.
REQ-022 frame_vld SHALL be low in every cycle except the one cycle after completion; back-to-back frames are permitted.
  - sof may accompany the bit following the last CRC bit.
REQ-023 Latency: frame_vld SHALL be visible one clock after the last CRC bit is presented.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
  - FSM to IDLE
  - counter and remainder to 0
  - data_out=0, crc_rem=0, crc_err=0, frame_vld=0, busy=0
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; no frame_vld SHALL follow deassertion until a new sof.

Verification
REQ-026 poly=4'b0011, DATA_W=8, stream A5 then B (bits 1010_0101_1011) with sof on the first bit:
  - frame_vld pulses once.
  - data_out=8'hA5, crc_err=0, crc_rem=0.
REQ-027 Same frame with CRC field 4'hA:
  - crc_err=1, crc_rem=4'h1.
  - data_out=8'hA5.
REQ-028 Same good frame with bit_vld deasserted for 3 cycles after bits 2 and 9:
  - Identical results to REQ-026.
  - frame_vld arrives 6 cycles later than in REQ-026.
REQ-029 Frame started, new sof after 5 payload bits, then a full good A5/B frame:
  - Exactly one frame_vld.
  - data_out=8'hA5, crc_err=0.
REQ-030 rst_n pulsed low (asynchronously, between clock edges) after the 6th bit:
  - All outputs go to 0 at once.
  - Remaining bits without sof produce no frame_vld; busy=0.
REQ-031 Two good frames back-to-back, second payload 8'h00 with CRC 4'h0:
  - Two frame_vld pulses, 12 cycles apart.
  - Final data_out=8'h00, crc_err=0.
